// File: rtl/dual_issue_sched_if.sv
// Queue-head, redirect/writeback and execute-pipe issue signals of the dual-issue scheduler.
// The queue/execute side uses master; the scheduler uses slave.
interface dual_issue_sched_if #(
    parameter int DEC_W = 64
);
    logic               stop;
    logic [1:0]         s_valid;
    logic [9:0]         s_rs1;
    logic [9:0]         s_rs2;
    logic [9:0]         s_rd;
    logic [1:0]         s_rs1_v;
    logic [1:0]         s_rs2_v;
    logic [1:0]         s_rfwe;
    logic [1:0]         s_is_mem;
    logic [1:0]         s_is_load;
    logic [1:0]         s_is_br;
    logic [2*DEC_W-1:0] s_dec;
    logic [1:0]         pop_cnt;
    logic               br_flag;
    logic               wb_valid;
    logic [4:0]         wb_addr;
    logic               p0_valid;
    logic               p1_valid;
    logic               p0_num;
    logic               p1_num;
    logic [DEC_W-1:0]   p0_dec;
    logic [DEC_W-1:0]   p1_dec;
    logic               busy_flush;

    modport master (
        output stop, s_valid, s_rs1, s_rs2, s_rd, s_rs1_v, s_rs2_v, s_rfwe,
               s_is_mem, s_is_load, s_is_br, s_dec, br_flag, wb_valid, wb_addr,
        input  pop_cnt, p0_valid, p1_valid, p0_num, p1_num, p0_dec, p1_dec, busy_flush
    );

    modport slave (
        input  stop, s_valid, s_rs1, s_rs2, s_rd, s_rs1_v, s_rs2_v, s_rfwe,
               s_is_mem, s_is_load, s_is_br, s_dec, br_flag, wb_valid, wb_addr,
        output pop_cnt, p0_valid, p1_valid, p0_num, p1_num, p0_dec, p1_dec, busy_flush
    );
endinterface

// File: rtl/dual_issue_sched.sv
// In-order dual-issue scheduler: picks up to two queue-head instructions, steers them
// to the two execute pipes, stalls on pending load destinations and squashes after redirects.
module dual_issue_sched #(
    parameter int DEC_W     = 64,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    dual_issue_sched_if.slave bus
);
    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               busy_flush_r;
    logic [31:0]        pend_r;
    logic [31:0]        pend_nxt_s;
    logic [31:0]        clr_mask_s;
    logic [31:0]        set0_mask_s;
    logic [31:0]        set1_mask_s;
    logic [4:0]         rs1_0_s, rs2_0_s, rd_0_s, rs1_1_s, rs2_1_s, rd_1_s;
    logic               haz0_s, haz1_s, raw_s, waw_s, pair_block_s;
    logic               iss0_s, iss1_s, swap_s, p0_take_s, p1_take_s;
    logic [DEC_W-1:0]   p0_src_s, p1_src_s;
    logic               p0_valid_r, p1_valid_r, p0_num_r, p1_num_r;
    logic [DEC_W-1:0]   p0_dec_r, p1_dec_r;
    logic               unused_s;

    assign rs1_0_s = bus.s_rs1[4:0];
    assign rs2_0_s = bus.s_rs2[4:0];
    assign rd_0_s  = bus.s_rd[4:0];
    assign rs1_1_s = bus.s_rs1[9:5];
    assign rs2_1_s = bus.s_rs2[9:5];
    assign rd_1_s  = bus.s_rd[9:5];
    assign unused_s = bus.s_is_br[1];

    assign haz0_s = (bus.s_rs1_v[0] & pend_r[rs1_0_s]) | (bus.s_rs2_v[0] & pend_r[rs2_0_s]);
    assign haz1_s = (bus.s_rs1_v[1] & pend_r[rs1_1_s]) | (bus.s_rs2_v[1] & pend_r[rs2_1_s]);
    assign raw_s  = bus.s_rfwe[0] & (rd_0_s != 5'd0) &
                    ((bus.s_rs1_v[1] & (rs1_1_s == rd_0_s)) | (bus.s_rs2_v[1] & (rs2_1_s == rd_0_s)));
    assign waw_s  = bus.s_rfwe[0] & bus.s_rfwe[1] & (rd_0_s != 5'd0) & (rd_0_s == rd_1_s);
    assign pair_block_s = bus.s_is_br[0] | raw_s | waw_s | (bus.s_is_mem[0] & bus.s_is_mem[1]);

    // A memory op at the head always owns pipe1, pushing its partner onto pipe0.
    assign swap_s    = bus.s_is_mem[0];
    assign p0_take_s = swap_s ? iss1_s : iss0_s;
    assign p1_take_s = swap_s ? iss0_s : iss1_s;
    assign p0_src_s  = swap_s ? bus.s_dec[2*DEC_W-1:DEC_W] : bus.s_dec[DEC_W-1:0];
    assign p1_src_s  = swap_s ? bus.s_dec[DEC_W-1:0] : bus.s_dec[2*DEC_W-1:DEC_W];

    // FSM state register, flush counter and registered flush indicator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RUN;
            cnt_r        <= {CNT_W{1'b0}};
            busy_flush_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            busy_flush_r <= (state_nxt_s == ST_FLUSH);
        end
    end

    // FSM next-state: redirects (re)load the squash window, which then counts down to RUN.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (bus.br_flag) begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (bus.br_flag) begin
                    cnt_nxt_s = CNT_LOAD;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM outputs: in-order issue decisions for the two head slots.
    always_comb begin
        iss0_s = 1'b0;
        iss1_s = 1'b0;
        if ((state_r == ST_RUN) && !rst && !bus.stop && !bus.br_flag) begin
            iss0_s = bus.s_valid[0] & ~haz0_s;
            iss1_s = bus.s_valid[0] & ~haz0_s & bus.s_valid[1] & ~haz1_s & ~pair_block_s;
        end else begin
            iss0_s = 1'b0;
            iss1_s = 1'b0;
        end
    end

    assign bus.pop_cnt = {1'b0, iss0_s} + {1'b0, iss1_s};

    // Same-cycle set beats writeback clear; x0 can never be pending.
    assign clr_mask_s  = bus.wb_valid ? (32'd1 << bus.wb_addr) : 32'd0;
    assign set0_mask_s = (iss0_s & bus.s_is_load[0] & bus.s_rfwe[0]) ? (32'd1 << rd_0_s) : 32'd0;
    assign set1_mask_s = (iss1_s & bus.s_is_load[1] & bus.s_rfwe[1]) ? (32'd1 << rd_1_s) : 32'd0;
    assign pend_nxt_s  = ((pend_r & ~clr_mask_s) | set0_mask_s | set1_mask_s) & ~32'd1;

    // Load-destination scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 32'd0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Issue registers: redirect clears valids even under stop; stop freezes everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_valid_r <= 1'b0;
            p1_valid_r <= 1'b0;
            p0_num_r   <= 1'b0;
            p1_num_r   <= 1'b1;
            p0_dec_r   <= {DEC_W{1'b0}};
            p1_dec_r   <= {DEC_W{1'b0}};
        end else if (bus.br_flag) begin
            p0_valid_r <= 1'b0;
            p1_valid_r <= 1'b0;
        end else if (!bus.stop) begin
            p0_valid_r <= p0_take_s;
            p1_valid_r <= p1_take_s;
            p0_num_r   <= iss0_s & swap_s;
            p1_num_r   <= ~(iss0_s & swap_s);
            if (p0_take_s) begin
                p0_dec_r <= p0_src_s;
            end
            if (p1_take_s) begin
                p1_dec_r <= p1_src_s;
            end
        end
    end

    assign bus.p0_valid   = p0_valid_r;
    assign bus.p1_valid   = p1_valid_r;
    assign bus.p0_num     = p0_num_r;
    assign bus.p1_num     = p1_num_r;
    assign bus.p0_dec     = p0_dec_r;
    assign bus.p1_dec     = p1_dec_r;
    assign bus.busy_flush = busy_flush_r;
endmodule

// File: tb/tb_dual_issue_sched.sv
// Bench for dual_issue_sched: directed instruction queue, behavioural issue model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_dual_issue_sched;
    localparam int DEC_W     = 64;
    localparam int FLUSH_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_issue_sched_if #(.DEC_W(DEC_W)) bus();
    dual_issue_sched #(.DEC_W(DEC_W), .FLUSH_CYC(FLUSH_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1;
        logic        r1v;
        logic [4:0]  rs2;
        logic        r2v;
        logic [4:0]  rd;
        logic        we;
        logic        mem;
        logic        ld;
        logic        br;
        logic [63:0] dec;
    } ins_t;

    ins_t        q[$];
    ins_t        cur[2];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          exp_pop = 0;
    bit          lit_on[8];
    logic [63:0] lit_val[8];
    int          lit_at = -1;
    string       lit_nm[8] = '{"lit_pop_cnt", "lit_p0_valid", "lit_p1_valid", "lit_p0_num",
                               "lit_p1_num", "lit_p0_dec", "lit_p1_dec", "lit_busy_flush"};

    // model state: pending loads, remaining squash cycles, expected pipe registers
    bit [31:0]   m_pend;
    int          m_flush;
    bit          m_init = 1'b0;
    bit          mv[2];
    bit          mn[2];
    logic [63:0] md[2];

    function automatic ins_t mk(input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                                input logic r1v, input logic [4:0] rs2, input logic r2v,
                                input logic mem, input logic ld, input logic [7:0] id);
        ins_t i;
        i.v = 1'b1; i.rd = rd; i.we = we; i.rs1 = rs1; i.r1v = r1v; i.rs2 = rs2; i.r2v = r2v;
        i.mem = mem; i.ld = ld; i.br = 1'b0; i.dec = {56'hD15C_0000_0000_00, id};
        return i;
    endfunction

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [7:0] id);
        return mk(rd, 1'b1, rs1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, id);
    endfunction

    function automatic bit haz(input ins_t i);
        return (i.r1v && m_pend[i.rs1]) || (i.r2v && m_pend[i.rs2]);
    endfunction

    // may the younger instruction b go out alongside the older a?
    function automatic bit pair_ok(input ins_t a, input ins_t b);
        bit dep;
        bit same_dst;
        dep      = a.we && a.rd != 5'd0 && ((b.r1v && b.rs1 == a.rd) || (b.r2v && b.rs2 == a.rd));
        same_dst = a.we && b.we && a.rd != 5'd0 && a.rd == b.rd;
        return !a.br && !dep && !same_dst && !(a.mem && b.mem);
    endfunction

    function automatic logic [63:0] sig(input int k);
        case (k)
            0: return 64'(bus.pop_cnt);
            1: return 64'(bus.p0_valid);
            2: return 64'(bus.p1_valid);
            3: return 64'(bus.p0_num);
            4: return 64'(bus.p1_num);
            5: return bus.p0_dec;
            6: return bus.p1_dec;
            default: return 64'(bus.busy_flush);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // compare process: checks DUT against model mid-cycle, then advances the model
    always @(negedge clk) begin
        int n;
        int pa;
        n = 0;
        if (!rst && m_flush == 0 && !bus.br_flag && !bus.stop && cur[0].v && !haz(cur[0])) n = 1;
        if (n == 1 && cur[1].v && !haz(cur[1]) && pair_ok(cur[0], cur[1])) n = 2;
        chk("pop_cnt", 64'(bus.pop_cnt), 64'(n));
        if (m_init) begin
            chk("busy_flush", 64'(bus.busy_flush), 64'(m_flush > 0));
            chk("p0_valid", 64'(bus.p0_valid), 64'(mv[0]));
            chk("p1_valid", 64'(bus.p1_valid), 64'(mv[1]));
            if (mv[0]) begin
                chk("p0_num", 64'(bus.p0_num), 64'(mn[0]));
                chk("p0_dec", bus.p0_dec, md[0]);
            end
            if (mv[1]) begin
                chk("p1_num", 64'(bus.p1_num), 64'(mn[1]));
                chk("p1_dec", bus.p1_dec, md[1]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (lit_at == cyc && lit_on[k]) chk(lit_nm[k], sig(k), lit_val[k]);
        end
        if (rst) begin
            m_pend = 32'd0; m_flush = 0; m_init = 1'b1;
            mv[0] = 1'b0; mv[1] = 1'b0; mn[0] = 1'b0; mn[1] = 1'b1; md[0] = 64'd0; md[1] = 64'd0;
        end else begin
            if (bus.wb_valid) m_pend[bus.wb_addr] = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (cur[k].ld && cur[k].we) m_pend[cur[k].rd] = 1'b1;
            end
            m_pend[0] = 1'b0;
            if (bus.br_flag) begin
                m_flush = FLUSH_CYC;
                mv[0] = 1'b0; mv[1] = 1'b0;
            end else begin
                if (m_flush > 0) m_flush--;
                if (!bus.stop) begin
                    mv[0] = 1'b0; mv[1] = 1'b0;
                    pa = cur[0].mem ? 1 : 0;
                    if (n >= 1) begin mv[pa] = 1'b1; mn[pa] = 1'b0; md[pa] = cur[0].dec; end
                    if (n == 2) begin mv[1-pa] = 1'b1; mn[1-pa] = 1'b1; md[1-pa] = cur[1].dec; end
                end
            end
        end
        exp_pop = n;
        cyc++;
    end

    task automatic drive();
        bus.s_valid   = {cur[1].v, cur[0].v};
        bus.s_rs1     = {cur[1].rs1, cur[0].rs1};
        bus.s_rs2     = {cur[1].rs2, cur[0].rs2};
        bus.s_rd      = {cur[1].rd, cur[0].rd};
        bus.s_rs1_v   = {cur[1].r1v, cur[0].r1v};
        bus.s_rs2_v   = {cur[1].r2v, cur[0].r2v};
        bus.s_rfwe    = {cur[1].we, cur[0].we};
        bus.s_is_mem  = {cur[1].mem, cur[0].mem};
        bus.s_is_load = {cur[1].ld, cur[0].ld};
        bus.s_is_br   = {cur[1].br, cur[0].br};
        bus.s_dec     = {cur[1].dec, cur[0].dec};
    endtask

    // advance one cycle: consume what issued, present the new queue head, drop pulses
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < exp_pop; k++) begin
            if (q.size() > 0) void'(q.pop_front());
        end
        for (int k = 0; k < 8; k++) lit_on[k] = 1'b0;
        bus.br_flag  = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_addr  = 5'd0;
        cur[0] = (q.size() > 0) ? q[0] : '0;
        cur[1] = (q.size() > 1) ? q[1] : '0;
        drive();
    endtask

    task automatic want(input int k, input logic [63:0] v);
        lit_on[k]  = 1'b1;
        lit_val[k] = v;
        lit_at     = cyc;
    endtask

    initial begin
        ins_t c1, h0, h1, l0, j1, e0, e1;
        bus.stop = 1'b0; bus.br_flag = 1'b0; bus.wb_valid = 1'b0; bus.wb_addr = 5'd0;
        cur[0] = '0; cur[1] = '0;
        drive();
        tick(); tick();
        want(1, 64'd0); want(2, 64'd0); want(3, 64'd0); want(4, 64'd1);
        want(5, 64'd0); want(6, 64'd0); want(7, 64'd0);
        rst = 1'b0;
        // two independent ALU ops dual-issue in order
        q.push_back(alu(5'd3, 5'd1, 8'h01)); q.push_back(alu(5'd4, 5'd1, 8'h02));
        tick(); want(0, 64'd2);
        tick(); want(1, 64'd1); want(2, 64'd1); want(3, 64'd0); want(4, 64'd1);
        want(5, 64'hD15C_0000_0000_0001); want(6, 64'hD15C_0000_0000_0002);
        // intra-pair RAW splits the pair; the younger goes alone on pipe0
        q.push_back(alu(5'd5, 5'd1, 8'h03)); q.push_back(alu(5'd6, 5'd5, 8'h04));
        tick(); want(0, 64'd1);
        tick(); want(0, 64'd1); want(1, 64'd1); want(2, 64'd0);
        tick(); want(1, 64'd1); want(3, 64'd0); want(5, 64'hD15C_0000_0000_0004); want(2, 64'd0);
        // load x7 stalls its consumer until writeback
        q.push_back(mk(5'd7, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'h05));
        c1 = alu(5'd8, 5'd7, 8'h06);
        q.push_back(c1);
        tick(); want(0, 64'd1);
        tick(); want(0, 64'd0); want(2, 64'd1); want(1, 64'd0); want(4, 64'd0);
        want(6, 64'hD15C_0000_0000_0005);
        tick(); want(0, 64'd0); want(2, 64'd0);
        tick(); bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; want(0, 64'd0);
        tick(); want(0, 64'd1);
        tick(); want(1, 64'd1); want(5, c1.dec);
        // load to x0 leaves nothing pending; two mem ops single-issue
        q.push_back(mk(5'd0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'h07));
        q.push_back(mk(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 8'h08));
        tick(); want(0, 64'd1);
        tick(); want(0, 64'd1); want(1, 64'd0); want(2, 64'd1);
        // store + ALU: store to pipe1 as older, ALU to pipe0 as younger
        e0 = mk(5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 8'h09);
        e1 = alu(5'd10, 5'd3, 8'h0A);
        q.push_back(e0); q.push_back(e1);
        tick(); want(0, 64'd2);
        q.push_back(alu(5'd11, 5'd1, 8'h0B)); q.push_back(alu(5'd12, 5'd1, 8'h0C));
        // redirect together with stop: valids still clear, squash for FLUSH_CYC cycles
        tick(); bus.br_flag = 1'b1; bus.stop = 1'b1;
        want(0, 64'd0); want(1, 64'd1); want(2, 64'd1); want(3, 64'd1); want(4, 64'd0);
        want(5, e1.dec); want(6, e0.dec);
        tick(); bus.stop = 1'b0; want(1, 64'd0); want(2, 64'd0); want(7, 64'd1); want(0, 64'd0);
        tick(); want(7, 64'd1); want(0, 64'd0);
        tick(); want(7, 64'd0); want(0, 64'd2);
        // second redirect inside the squash window extends it
        q.push_back(alu(5'd18, 5'd1, 8'h0D)); q.push_back(alu(5'd19, 5'd1, 8'h0E));
        tick(); bus.br_flag = 1'b1; want(0, 64'd0);
        tick(); bus.br_flag = 1'b1; want(7, 64'd1);
        tick(); want(7, 64'd1); want(0, 64'd0);
        tick(); want(7, 64'd1); want(0, 64'd0);
        tick(); want(7, 64'd0); want(0, 64'd2);
        // stop for three cycles freezes outputs while writeback still clears the scoreboard
        l0 = mk(5'd15, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'h10);
        h0 = alu(5'd13, 5'd15, 8'h11);
        h1 = alu(5'd14, 5'd2, 8'h12);
        q.push_back(l0); q.push_back(h0); q.push_back(h1);
        tick(); want(0, 64'd1);
        tick(); bus.stop = 1'b1; bus.wb_valid = 1'b1; bus.wb_addr = 5'd15;
        want(0, 64'd0); want(2, 64'd1); want(6, l0.dec);
        tick(); want(0, 64'd0); want(2, 64'd1); want(6, l0.dec);
        tick(); want(0, 64'd0); want(2, 64'd1); want(6, l0.dec);
        tick(); bus.stop = 1'b0; want(2, 64'd1); want(6, l0.dec); want(0, 64'd2);
        tick(); want(1, 64'd1); want(5, h0.dec); want(2, 64'd1); want(6, h1.dec);
        // reset during the squash window restores everything and empties the scoreboard
        q.push_back(mk(5'd16, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'h13));
        j1 = alu(5'd17, 5'd16, 8'h14);
        q.push_back(j1);
        tick(); want(0, 64'd1);
        tick(); bus.br_flag = 1'b1; want(0, 64'd0);
        tick(); rst = 1'b1; want(7, 64'd1);
        tick(); rst = 1'b0;
        want(1, 64'd0); want(2, 64'd0); want(3, 64'd0); want(4, 64'd1);
        want(5, 64'd0); want(6, 64'd0); want(7, 64'd0); want(0, 64'd1);
        tick(); want(1, 64'd1); want(5, j1.dec);
        tick(); tick();
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
